// File: rtl/cw305_reg_bank_if.sv
// Byte-wide register bus between a host bridge (master) and a register bank (slave).
interface cw305_reg_bank_if #(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 7
);
    logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address;
    logic [pBYTECNT_SIZE-1:0]             reg_bytecnt;
    logic [7:0]                           write_data;
    logic                                 reg_read;
    logic                                 reg_write;
    logic                                 reg_addrvalid;
    logic [7:0]                           read_data;

    modport master (
        output reg_address, reg_bytecnt, write_data, reg_read, reg_write, reg_addrvalid,
        input  read_data
    );

    modport slave (
        input  reg_address, reg_bytecnt, write_data, reg_read, reg_write, reg_addrvalid,
        output read_data
    );
endinterface

// File: rtl/cw305_reg_bank.sv
// Register bank for a CW305-style target: input channels, captured output channels,
// and a go/busy/done sequencer with cycle counting and timeout.
module cw305_reg_bank #(
    parameter int          pADDR_WIDTH   = 21,
    parameter int          pBYTECNT_SIZE = 7,
    parameter int          pIN_CH        = 4,
    parameter int          pOUT_CH       = 2,
    parameter int          pDATA_WIDTH   = 128,
    parameter int          pTIMEOUT      = 65535,
    parameter logic [7:0]  pIDENTIFY     = 8'h2e
) (
    input  logic                           usb_clk,
    input  logic                           reset_n,
    cw305_reg_bank_if.slave                bus,
    output logic [pIN_CH*pDATA_WIDTH-1:0]  O_datain,
    input  logic [pOUT_CH*pDATA_WIDTH-1:0] I_dataout,
    input  logic                           I_ready,
    input  logic                           I_done,
    output logic                           O_start,
    output logic                           O_busy,
    output logic                           O_irq
);
    localparam int AW     = pADDR_WIDTH - pBYTECNT_SIZE;
    localparam int BC     = pBYTECNT_SIZE;
    localparam int NBYTES = pDATA_WIDTH / 8;
    localparam logic [31:0] TMO = 32'(pTIMEOUT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;

    logic [pDATA_WIDTH-1:0] in_ch_reg  [pIN_CH];
    logic [pDATA_WIDTH-1:0] out_ch_reg [pOUT_CH];

    logic [1:0]  state_reg, state_next;
    logic [31:0] counter_reg, counter_next;
    logic [31:0] cycles_reg, cycles_next;
    logic [2:0]  status_reg, status_next;
    logic        irq_reg;
    logic [7:0]  read_data_reg;

    logic [pIN_CH-1:0]  in_sel;
    logic [pOUT_CH-1:0] out_sel;
    logic [NBYTES-1:0]  byte_sel;

    logic wr, rd, busy, byte_ok, byte0;
    logic is_ident, is_ctrl, is_status, is_cycles;
    logic ctrl_wr, go, clr, in_wr_any, capture;
    logic set_done, set_to, set_ov;
    logic [31:0] cnt_inc;

    logic [pDATA_WIDTH-1:0] rd_word, rd_shift;
    logic [31:0]            cy_shift;
    logic [7:0]             rd_byte;

    genvar gi;
    generate
        for (gi = 0; gi < pIN_CH; gi++) begin : g_in
            assign in_sel[gi] = (bus.reg_address == AW'(16 + gi));
            assign O_datain[gi*pDATA_WIDTH +: pDATA_WIDTH] = in_ch_reg[gi];
        end
        for (gi = 0; gi < pOUT_CH; gi++) begin : g_out
            assign out_sel[gi] = (bus.reg_address == AW'(32 + gi));
        end
        for (gi = 0; gi < NBYTES; gi++) begin : g_byte
            assign byte_sel[gi] = (bus.reg_bytecnt == BC'(gi));
        end
    endgenerate

    assign wr        = bus.reg_addrvalid && bus.reg_write;
    assign rd        = bus.reg_addrvalid && bus.reg_read;
    assign busy      = (state_reg != S_IDLE);
    assign byte_ok   = |byte_sel;
    assign byte0     = byte_sel[0];
    assign is_ident  = (bus.reg_address == AW'(0));
    assign is_ctrl   = (bus.reg_address == AW'(1));
    assign is_status = (bus.reg_address == AW'(2));
    assign is_cycles = (bus.reg_address == AW'(3));

    assign ctrl_wr   = wr && is_ctrl && byte0;
    assign go        = ctrl_wr && bus.write_data[0];
    assign clr       = ctrl_wr && bus.write_data[1];
    assign in_wr_any = wr && (|in_sel) && byte_ok;
    assign cnt_inc   = (counter_reg == 32'hFFFF_FFFF) ? counter_reg : counter_reg + 32'd1;

    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        cycles_next  = cycles_reg;
        capture      = 1'b0;
        set_done     = 1'b0;
        set_to       = 1'b0;
        set_ov       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (go) begin
                    if (I_ready) state_next = S_START;
                    else         set_ov     = 1'b1;
                end
            end
            S_START: begin
                counter_next = 32'd0;
                state_next   = S_BUSY;
            end
            S_BUSY: begin
                counter_next = cnt_inc;
                // done is checked first so it wins over a coincident timeout
                if (I_done) begin
                    capture     = 1'b1;
                    cycles_next = cnt_inc;
                    set_done    = 1'b1;
                    state_next  = S_IDLE;
                end else if (cnt_inc >= TMO) begin
                    set_to     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (busy && (go || in_wr_any)) set_ov = 1'b1;
        status_next = (clr ? 3'b000 : status_reg) | {set_ov, set_to, set_done};
    end

    always_comb begin
        rd_word = '0;
        rd_byte = 8'h00;
        for (int i = 0; i < pIN_CH; i++)  if (in_sel[i])  rd_word = in_ch_reg[i];
        for (int j = 0; j < pOUT_CH; j++) if (out_sel[j]) rd_word = out_ch_reg[j];
        rd_shift = rd_word >> {bus.reg_bytecnt, 3'b000};
        cy_shift = cycles_reg >> {bus.reg_bytecnt, 3'b000};
        if ((|in_sel || |out_sel) && byte_ok)            rd_byte = rd_shift[7:0];
        else if (is_cycles && bus.reg_bytecnt < BC'(4))  rd_byte = cy_shift[7:0];
        else if (byte0 && is_ident)                      rd_byte = pIDENTIFY;
        else if (byte0 && is_ctrl)                       rd_byte = {7'd0, busy};
        else if (byte0 && is_status)                     rd_byte = {5'd0, status_reg};
    end

    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            counter_reg   <= 32'd0;
            cycles_reg    <= 32'd0;
            status_reg    <= 3'b000;
            irq_reg       <= 1'b0;
            read_data_reg <= 8'h00;
        end else begin
            state_reg     <= state_next;
            counter_reg   <= counter_next;
            cycles_reg    <= cycles_next;
            status_reg    <= status_next;
            irq_reg       <= status_next[0] | status_next[1];
            read_data_reg <= rd ? rd_byte : 8'h00;
        end
    end

    // Input channels are frozen while an operation is in flight
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < pIN_CH; i++) in_ch_reg[i] <= '0;
        end else if (in_wr_any && !busy) begin
            for (int i = 0; i < pIN_CH; i++)
                for (int j = 0; j < NBYTES; j++)
                    if (in_sel[i] && byte_sel[j]) in_ch_reg[i][j*8 +: 8] <= bus.write_data;
        end
    end

    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < pOUT_CH; j++) out_ch_reg[j] <= '0;
        end else if (capture) begin
            for (int j = 0; j < pOUT_CH; j++)
                out_ch_reg[j] <= I_dataout[j*pDATA_WIDTH +: pDATA_WIDTH];
        end
    end

    assign bus.read_data = read_data_reg;
    assign O_start       = (state_reg == S_START);
    assign O_busy        = busy;
    assign O_irq         = irq_reg;
endmodule

// File: doc/cw305_reg_bank.md
CW305_REG_BANK -- requirements
Module: cw305_reg_bank

Interface
REQ-001 SHALL have parameter pADDR_WIDTH, default 21, total register-bus address width.
REQ-002 SHALL have parameter pBYTECNT_SIZE, default 7, byte-index width within a register.
REQ-003 SHALL have parameter pIN_CH, default 4, number of write/read input data channels (1..16).
REQ-004 SHALL have parameter pOUT_CH, default 2, number of read-only captured output channels (1..16).
REQ-005 SHALL have parameter pDATA_WIDTH, default 128, width of every channel, a multiple of 8.
REQ-006 SHALL have parameter pTIMEOUT, default 65535, maximum BUSY cycles before abort (>=1).
REQ-007 SHALL have parameter pIDENTIFY, default 8'h2e, identify byte.
REQ-008 SHALL have port usb_clk  in  1  single clock; all logic is on its rising edge.
REQ-009 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-010 SHALL have ports reg_address  in  pADDR_WIDTH-pBYTECNT_SIZE, reg_bytecnt  in  pBYTECNT_SIZE, write_data  in  8, reg_read/reg_write/reg_addrvalid  in  1 each, read_data  out  8.
REQ-011 SHALL have ports O_datain  out  pIN_CH*pDATA_WIDTH (channel i at bits [i*pDATA_WIDTH +: pDATA_WIDTH]), I_dataout  in  pOUT_CH*pDATA_WIDTH, same packing.
REQ-012 SHALL have ports I_ready  in  1, I_done  in  1, O_start  out  1, O_busy  out  1, O_irq  out  1.

Function
REQ-013 Address map SHALL be: 0x00 IDENTIFY (RO); 0x01 CTRL (W bit0 go, bit1 clear status; R bit0 = O_busy); 0x02 STATUS (RO bit0 done, bit1 timeout, bit2 overrun); 0x03 CYCLES (RO 32 bit); 0x10+i input channel i (RW); 0x20+j output channel j (RO).
REQ-014 Byte access SHALL use reg_bytecnt as byte index, byte 0 = bits [7:0].
REQ-015 Reads SHALL be registered: read_data equals the addressed byte one cycle after reg_addrvalid && reg_read; otherwise 0 next cycle.
REQ-016 Unmapped address, channel index >= pIN_CH/pOUT_CH, or byte index >= pDATA_WIDTH/8 (>=4 for CYCLES) SHALL read 0; such writes SHALL be ignored.
REQ-017 A write takes effect on the usb_clk edge where reg_addrvalid && reg_write.
REQ-018 FSM states SHALL be IDLE, START, BUSY; O_busy = 1 in START and BUSY.
REQ-019 IDLE: go write with I_ready=1 -> START; go with I_ready=0 -> stay IDLE, set overrun.
REQ-020 START lasts exactly one cycle with O_start=1, clears CYCLES counter to 0, then -> BUSY.
REQ-021 BUSY: counter increments by 1 per cycle, saturating at 2^32-1.
REQ-022 BUSY with I_done=1: capture all I_dataout channels, latch counter (including that cycle) into CYCLES, set done, -> IDLE.
REQ-023 BUSY when counter reaches pTIMEOUT without I_done: set timeout, output channels and CYCLES unchanged, -> IDLE.
REQ-024 I_done and timeout in the same cycle: done SHALL win.
REQ-025 I_done outside BUSY SHALL be ignored.
REQ-026 Go write while O_busy=1 SHALL be ignored and set overrun.
REQ-027 Input channel writes while O_busy=1 SHALL be ignored and set overrun; O_datain stays stable for the whole operation.
REQ-028 Status bits SHALL be sticky until CTRL bit1 write; clear and a same-cycle set event: set wins.
REQ-029 CTRL write with both bit0 and bit1 set SHALL clear status first, then evaluate go.
REQ-030 O_irq SHALL be registered OR of done and timeout status bits.

Reset
REQ-031 reset_n low SHALL immediately force: FSM IDLE, O_start=0, O_busy=0, O_irq=0, read_data=0, status=0, CYCLES=0, all input and output channel registers 0.
REQ-032 Reset asserted mid-operation SHALL abort without capture; after release, first go behaves as from power-up.

Verification
REQ-033 Write channel 0 bytes 0..15 = 0x00..0x0F, read back -> same bytes, O_datain[127:0] = 0x0F0E..0100.
REQ-034 Go with I_ready=1, I_done after 10 BUSY cycles, I_dataout ch1 = 0xA5 repeated -> O_start one cycle, 0x21 reads 0xA5, CYCLES = 10, STATUS = 0x01, O_irq=1.
REQ-035 pTIMEOUT=8, go, no I_done -> IDLE after 8 BUSY cycles, STATUS = 0x02, output channels unchanged.
REQ-036 Go and channel write during BUSY -> both ignored, STATUS bit2 = 1, O_datain unchanged; CTRL=0x02 -> STATUS = 0x00.
REQ-037 Reset pulse during BUSY -> O_busy=0 immediately, all registers 0, next go starts cleanly.
REQ-038 Read 0x10 byte 20 (pDATA_WIDTH=128) and address 0x3F -> 0x00; go with I_ready=0 -> no O_start, STATUS = 0x04.
